// File: rtl/alu_bist.sv
// Built-in self-test sequencer for a 32-bit ALU: drives operand vectors
// (one fixed, the rest from a Galois LFSR) through ADD/SUB/OR/AND, checks the
// returned result, and reports error count and first failing vector/op.
module alu_bist #(
    parameter int unsigned NUM_VEC = 16,
    parameter logic [31:0] SEED    = 32'h1234_5678
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic [31:0] ALUA,
    output logic [31:0] ALUB,
    output logic [2:0]  ALUOp,
    input  logic [31:0] ALU,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [7:0]  err_cnt,
    output logic [10:0] first_fail
);

    typedef enum logic [1:0] {IDLE, DRIVE, CHECK, DONE} state_t;

    localparam logic [7:0]  LAST_VEC = 8'(NUM_VEC - 1);
    localparam logic [31:0] VEC0_A   = 32'hFFFF_FF0F;
    localparam logic [31:0] VEC0_B   = 32'h4000_0000;
    localparam logic [31:0] POLY     = 32'h8020_0003;

    state_t      state_q, state_d;
    logic [31:0] a_q, a_d, b_q, b_d, lfsr_q, lfsr_d;
    logic [2:0]  op_q, op_d;
    logic [7:0]  vec_q, vec_d;
    logic [7:0]  err_q, err_d;
    logic [10:0] ff_q, ff_d;
    logic [31:0] expected;
    logic [31:0] next_a, next_b;
    logic        start_run, last_op, last_vec, mismatch;

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ POLY) : (s >> 1);
    endfunction

    assign start_run = start && (state_q == IDLE || state_q == DONE);
    assign last_op   = (op_q == 3'd3);
    assign last_vec  = (vec_q == LAST_VEC);
    assign next_a    = lfsr_step(lfsr_q);
    assign next_b    = lfsr_step(next_a);
    assign mismatch  = (ALU != expected);

    // Reference result for the operands currently driven to the ALU
    always_comb begin
        case (op_q)
            3'd0:    expected = a_q + b_q;
            3'd1:    expected = a_q - b_q;
            3'd2:    expected = a_q | b_q;
            default: expected = a_q & b_q;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = DRIVE;
            DRIVE:   state_d = CHECK;
            CHECK:   state_d = (last_op && last_vec) ? DONE : DRIVE;
            DONE:    if (start) state_d = DRIVE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy = (state_q == DRIVE) || (state_q == CHECK);
        done = (state_q == DONE);
        pass = done && (err_q == '0);
    end

    // Datapath next-state: run setup, result checking, operand sequencing
    always_comb begin
        a_d    = a_q;
        b_d    = b_q;
        op_d   = op_q;
        vec_d  = vec_q;
        err_d  = err_q;
        ff_d   = ff_q;
        lfsr_d = lfsr_q;
        if (start_run) begin
            a_d    = VEC0_A;
            b_d    = VEC0_B;
            op_d   = '0;
            vec_d  = '0;
            err_d  = '0;
            ff_d   = '0;
            lfsr_d = SEED;
        end else if (state_q == CHECK) begin
            if (mismatch) begin
                if (err_q != 8'hFF) err_d = err_q + 8'd1;
                if (err_q == '0)    ff_d  = {vec_q, op_q};
            end
            // After the final op of the final vector, operands stay put for DONE
            if (!last_op) begin
                op_d = op_q + 3'd1;
            end else if (!last_vec) begin
                op_d   = '0;
                vec_d  = vec_q + 8'd1;
                a_d    = next_a;
                b_d    = next_b;
                lfsr_d = next_b;
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            a_q    <= '0;
            b_q    <= '0;
            op_q   <= '0;
            vec_q  <= '0;
            err_q  <= '0;
            ff_q   <= '0;
            lfsr_q <= '0;
        end else begin
            a_q    <= a_d;
            b_q    <= b_d;
            op_q   <= op_d;
            vec_q  <= vec_d;
            err_q  <= err_d;
            ff_q   <= ff_d;
            lfsr_q <= lfsr_d;
        end
    end

    assign ALUA       = a_q;
    assign ALUB       = b_q;
    assign ALUOp      = op_q;
    assign err_cnt    = err_q;
    assign first_fail = ff_q;

endmodule

// File: tb/tb_alu_bist.sv
// Scoreboard bench for alu_bist: a behavioural model predicts the operand
// sequence and the end-of-run report; a monitor checks what the DUT presents.
module tb_alu_bist;

    localparam int unsigned NV   = 64;
    localparam logic [31:0] SEEDV = 32'h1234_5678;

    logic        clk = 1'b0;
    logic        reset, start;
    logic [31:0] ALUA, ALUB, ALU;
    logic [2:0]  ALUOp;
    logic        busy, done, pass;
    logic [7:0]  err_cnt;
    logic [10:0] first_fail;

    int errors = 0;
    int checks = 0;
    int mode   = 0;   // 0 good ALU, 1 AND stuck at 0, 2 always 0

    typedef struct { logic [31:0] a; logic [31:0] b; logic [2:0] op; } op_t;
    typedef struct { logic [7:0] err; logic [10:0] ff; logic pass; } res_t;
    op_t  op_sb[$];
    res_t res_sb[$];

    always #5 clk = ~clk;

    alu_bist #(.NUM_VEC(NV), .SEED(SEEDV)) dut (
        .clk(clk), .reset(reset), .start(start),
        .ALUA(ALUA), .ALUB(ALUB), .ALUOp(ALUOp), .ALU(ALU),
        .busy(busy), .done(done), .pass(pass),
        .err_cnt(err_cnt), .first_fail(first_fail)
    );

    function automatic logic [31:0] true_result(logic [31:0] a, logic [31:0] b, int op);
        case (op)
            0:       return a + b;
            1:       return a - b;
            2:       return a | b;
            default: return a & b;
        endcase
    endfunction

    function automatic logic [31:0] faulty_alu(logic [31:0] a, logic [31:0] b, int op, int m);
        if (m == 2) return 32'd0;
        if (m == 1 && op == 3) return 32'd0;
        if (op > 3) return 32'd0;
        return true_result(a, b, op);
    endfunction

    // ALU under test, with selectable fault
    always_comb ALU = faulty_alu(ALUA, ALUB, int'(ALUOp), mode);

    function automatic logic [31:0] lstep(logic [31:0] s);
        logic [31:0] r;
        r = s / 2;
        if (s % 2 == 1) r = r ^ 32'h8020_0003;
        return r;
    endfunction

    task automatic check(string name, logic [66:0] act, logic [66:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Predict one full run for the given ALU fault mode
    task automatic push_run(int m);
        logic [31:0] s, a, b, t;
        int e;
        logic [10:0] ff;
        op_t o;
        res_t r;
        s = SEEDV; e = 0; ff = '0;
        for (int v = 0; v < int'(NV); v++) begin
            if (v == 0) begin
                a = 32'hFFFF_FF0F; b = 32'h4000_0000;
            end else begin
                a = lstep(s); b = lstep(a); s = b;
            end
            for (int op = 0; op < 4; op++) begin
                o.a = a; o.b = b; o.op = 3'(op);
                op_sb.push_back(o);
                t = true_result(a, b, op);
                if (faulty_alu(a, b, op, m) != t) begin
                    if (e == 0) ff = {8'(v), 3'(op)};
                    e++;
                end
            end
        end
        r.err  = (e > 255) ? 8'd255 : 8'(e);
        r.ff   = ff;
        r.pass = (e == 0);
        res_sb.push_back(r);
    endtask

    // Monitor: each new operand triple while busy, and each run completion
    initial begin
        logic pb, pd;
        logic [66:0] prev;
        int cyc;
        op_t o;
        res_t r;
        pb = 0; pd = 0; prev = '0; cyc = 0;
        forever begin
            @(negedge clk);
            if (reset !== 1'b1) begin
                pb = 0; pd = 0;
            end else begin
                if (busy && (!pb || {ALUA, ALUB, ALUOp} != prev)) begin
                    if (op_sb.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_op: got %h expected none", {ALUA, ALUB, ALUOp});
                    end else begin
                        o = op_sb.pop_front();
                        check("operands", {ALUA, ALUB, ALUOp}, {o.a, o.b, o.op});
                    end
                end
                if (busy && !pb) cyc = 0;
                else             cyc++;
                if (done && !pd) begin
                    check("run_cycles", 67'(cyc), 67'(8 * NV));
                    if (res_sb.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_done: got done expected none");
                    end else begin
                        r = res_sb.pop_front();
                        check("report", {err_cnt, first_fail, pass}, {r.err, r.ff, r.pass});
                    end
                end
                pb = busy; pd = done;
                prev = {ALUA, ALUB, ALUOp};
            end
        end
    end

    task automatic wait_done();
        for (int i = 0; i < int'(8 * NV) + 20; i++) begin
            if (done) return;
            @(posedge clk); #1;
        end
        checks++; errors++;
        $display("FAIL done_timeout: got done=%0b expected 1", done);
    endtask

    task automatic run_pulse(int m);
        mode = m;
        push_run(m);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_done();
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0; start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", 67'({ALUA, ALUB, ALUOp, busy, done, pass, err_cnt, first_fail}), '0);
        reset = 1'b1;

        run_pulse(0);
        check("good_pass", 67'(pass), 67'(1));

        run_pulse(1);
        check("and_first_fail", 67'(first_fail), 67'({8'd0, 3'b011}));

        // Restart straight from DONE after a failing run
        push_run(1);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        check("restart_clear", 67'({err_cnt, first_fail, done, busy}), 67'({8'd0, 11'd0, 1'b0, 1'b1}));
        wait_done();
        repeat (2) @(posedge clk);
        #1;

        run_pulse(2);
        check("zero_first_fail", 67'(first_fail), 67'({8'd0, 3'b000}));

        // Abort during CHECK of vector 3 (cycle 25 after DRIVE entry)
        mode = 0;
        push_run(0);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (25) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;
        check("midrun_reset", 67'({ALUA, ALUB, ALUOp, busy, done, pass, err_cnt, first_fail}), '0);
        op_sb.delete();
        res_sb.delete();
        reset = 1'b1;
        run_pulse(0);

        // start held high for a whole run
        mode = 0;
        push_run(0);
        push_run(0);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1;
        wait_done();
        @(posedge clk); #1;
        check("held_restart", 67'({busy, done}), 67'({1'b1, 1'b0}));
        start = 1'b0;
        wait_done();
        repeat (3) @(posedge clk);
        #1;

        check("sb_empty", 67'(op_sb.size() + res_sb.size()), '0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_bist.md
ALU_BIST -- requirements
Module: alu_bist

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset; the clock port is named clk and the reset port is named reset.
REQ-002 Parameter NUM_VEC, default 16, SHALL give the number of operand vectors per run, legal range 1..256.
REQ-003 Parameter SEED, default 32'h1234_5678, SHALL be the LFSR seed, nonzero.
REQ-004 Port clk, input, 1 bit, SHALL be the rising-edge clock.
REQ-005 Port reset, input, 1 bit, SHALL be the synchronous reset, active when 0.
REQ-006 Port start, input, 1 bit, SHALL request a self-test run when 1.
REQ-007 Port ALUA, output, 32 bits, SHALL be the registered operand A driven to the ALU under test.
REQ-008 Port ALUB, output, 32 bits, SHALL be the registered operand B driven to the ALU under test.
REQ-009 Port ALUOp, output, 3 bits, SHALL be the registered operation select.
REQ-010 Port ALU, input, 32 bits, SHALL be the combinational result returned by the ALU under test.
REQ-011 Port busy, output, 1 bit, SHALL be 1 while a run is in progress.
REQ-012 Port done, output, 1 bit, SHALL be 1 after a run completes, until the next start or reset.
REQ-013 Port pass, output, 1 bit, SHALL be 1 when done=1 and err_cnt=0.
REQ-014 Port err_cnt, output, 8 bits, SHALL count mismatches, saturating at 255.
REQ-015 Port first_fail, output, 11 bits, SHALL hold {vector index[7:0], ALUOp[2:0]} of the first mismatch, and 0 if there is none.

Function
REQ-016 The ALUOp encoding SHALL be: 000 ADD (A+B mod 2^32), 001 SUB (A-B mod 2^32), 010 OR, 011 AND; codes 100..111 SHALL never be driven.
REQ-017 The FSM SHALL have the states IDLE, DRIVE, CHECK and DONE.
REQ-018 IDLE SHALL go to DRIVE on start=1, clearing err_cnt, first_fail, done and the vector and op counters, and loading the LFSR with SEED.
REQ-019 DRIVE SHALL last one cycle: it holds ALUA, ALUB and ALUOp stable, and the next state SHALL be CHECK.
REQ-020 CHECK SHALL last one cycle; on its closing edge the block SHALL compare the ALU input with the expected value computed internally from the registered ALUA, ALUB and ALUOp.
REQ-021 On a mismatch, err_cnt SHALL increment (saturating at 255); if err_cnt was 0, first_fail SHALL be loaded.
REQ-022 After CHECK: if ALUOp<011, ALUOp SHALL increment and the next state SHALL be DRIVE; otherwise ALUOp SHALL be set to 000 and the vector index SHALL increment.
REQ-023 Once the last vector (index NUM_VEC-1) finishes with op 011, the next state SHALL be DONE.
REQ-024 Vector 0 SHALL be fixed: ALUA=32'hFFFF_FF0F and ALUB=32'h4000_0000.
REQ-025 For vector k>=1, ALUA SHALL be one step of the LFSR state and ALUB the following step; the LFSR SHALL advance two steps per vector.
REQ-026 The LFSR SHALL be a 32-bit Galois LFSR that shifts right and XORs in 32'h8020_0003 when bit 0 is 1.
REQ-027 A run SHALL take exactly 8*NUM_VEC cycles from the first DRIVE cycle to the entry into DONE.
REQ-028 busy SHALL be 1 in DRIVE and CHECK, and 0 otherwise.
REQ-029 In DONE, done SHALL be 1; start=1 in DONE SHALL restart the run exactly as from IDLE.
REQ-030 start SHALL be ignored while busy=1.
REQ-031 ALUA, ALUB and ALUOp SHALL hold their last values in IDLE and DONE.

Reset
REQ-032 While reset=0 at a clock edge, the state SHALL become IDLE and ALUA, ALUB, ALUOp, busy, done, pass, err_cnt and first_fail SHALL all become 0, including when reset is asserted mid-run.
REQ-033 Reset SHALL take priority over start on the same edge.

Verification
REQ-034 Correct ALU model, NUM_VEC=1, pulse start -> ALU sequence 3FFF_FF0F, BFFF_FF0F, FFFF_FF0F, 4000_0000; done=1 and pass=1 exactly 8 cycles after DRIVE entry.
REQ-035 Model with AND stuck at 0, NUM_VEC=16 -> err_cnt=16 and first_fail={8'd0,3'b011}; pass=0.
REQ-036 Model that always returns 0, NUM_VEC=256 -> err_cnt saturates at 255; done=1 after 2048 cycles.
REQ-037 reset=0 asserted during CHECK of vector 3 -> next cycle all outputs are 0 and the state is IDLE; a following start reruns the test from vector 0.
REQ-038 start held high through an entire run -> no restart while busy; the block re-enters DRIVE on the cycle after DONE.
REQ-039 start in DONE after a failing run -> err_cnt and first_fail are cleared on that edge and the run repeats with identical operand values.
